i2c_target: RTL and testbench
=============================

# i2c_target

I2C responder (slave) that lets an external I2C controller read and write the gateware's byte-addressed configuration space over the same two-wire bus the FPGA normally masters. It is 7-bit addressed and supports standard/fast mode, with no clock stretching. It emulates a simple EEPROM-style device:

- A write sets an 8-bit register pointer, then writes data bytes at that pointer with auto-increment.
- A read returns bytes from the pointer with auto-increment.

Storage lives in the fabric, reached through a single-cycle write-strobe and read-fetch port. The block sits beside `i2c_bus2` on the I2C pins, with its `sda_t` ANDed into the pad tristate.

## Interface
Parameters:
- `DEV_ADDR`, default 7'h56: 7-bit target address the block responds to.
- `FILTER_LEN`, default 3: number of consecutive equal synchronized samples required before SCL/SDA change state.

Ports:
- `clk`  in  1  system clock; at least 20x the SCL rate.
- `rst`  in  1  reset, asynchronous, active-low (`rst`=0 resets).
- `scl_i`  in  1  SCL pad input.
- `sda_i`  in  1  SDA pad input.
- `sda_o`  out  1  SDA output value; constant 0 (open drain).
- `sda_t`  out  1  SDA tristate: 1 = release, 0 = pull low. Reset value 1.
- `wr_valid`  out  1  one-cycle pulse: write `wr_data` to `wr_addr`. Reset value 0.
- `wr_addr`  out  8  write address. Reset value 0.
- `wr_data`  out  8  write data. Reset value 0.
- `rd_strobe`  out  1  one-cycle pulse: the block samples `rd_data` this cycle. Reset value 0.
- `rd_addr`  out  8  current pointer, used as the read address. Reset value 0.
- `rd_data`  in  8  read data for `rd_addr`, valid combinationally in the `rd_strobe` cycle.
- `busy`  out  1  high from an addressed START until STOP or NACK-terminated read. Reset value 0.

## Operation
- **Input conditioning:** 2-flop synchronizer, then a stability filter. `scl_f`/`sda_f` update only after `FILTER_LEN` equal samples. Reset value of both filtered signals is 1.
- **Edge and condition detection:** rise/fall detection on the filtered signals.
  - START: `sda_f` falls while `scl_f` = 1.
  - STOP: `sda_f` rises while `scl_f` = 1.
- **Bit timing:** bits are sampled on SCL rise, MSB first. `sda_t` changes only on SCL fall.
- **States and transitions:**
  - IDLE: wait for START.
  - ADDR: shift in 8 bits. If addr = `DEV_ADDR`, go to ADDR_ACK. Otherwise go to IGNORE.
  - ADDR_ACK: pull SDA low from the 8th SCL fall to the 9th SCL fall. Then:
    - R/W = 0: go to WR_BYTE; the next byte is the pointer.
    - R/W = 1: load `rd_data`, pulse `rd_strobe`, increment ptr, then go to RD_BYTE.
  - WR_BYTE: shift 8 bits.
    - First byte after the address: ptr ← byte.
    - Later bytes: pulse `wr_valid` with `wr_addr` = ptr and `wr_data` = byte in the cycle after the 8th SCL rise, then ptr+1.
    - Then go to WR_ACK.
  - WR_ACK: drive ACK as in ADDR_ACK, then go to WR_BYTE.
  - RD_BYTE: drive 8 bits, with `sda_t` = bit. Release SDA at the 8th SCL fall, then go to RD_ACK.
  - RD_ACK: sample the controller's bit at the 9th SCL rise.
    - ACK (0): at the 9th SCL fall, load the next byte (`rd_strobe`, ptr+1) and go to RD_BYTE.
    - NACK (1): go to IGNORE.
  - IGNORE: `sda_t` = 1 and no strobes; wait for START or STOP.
- **Pointer:** 8 bits, wraps 8'hFF → 8'h00. It persists across transactions until reset; only a pointer byte changes it.
- **START (including repeated START) in any state:** bit counter ← 0, `sda_t` ← 1, go to ADDR. ptr is kept.
- **STOP in any state:** go to IDLE, `sda_t` ← 1, `busy` ← 0.
- **Simultaneous events:** START/STOP detection takes priority over data-bit handling in the same cycle. A STOP after a partial byte discards that byte, and `wr_valid` does not fire.
- **General call (addr 0):** not acknowledged.

## Timing
- Filter latency: 2 + `FILTER_LEN` clk cycles from pad to `scl_f`/`sda_f`.
- `sda_t` updates 1 clk after the filtered SCL fall. This gives a data hold of at least 5 clk after the pad SCL fall, and meets the 400 kHz tLOW spec for clk ≥ 10 MHz.
- `wr_valid`: 1 clk after the filtered 8th SCL rise, exactly 1 cycle wide. `wr_addr`/`wr_data` hold until the next pulse.
- `rd_strobe`: 1 clk wide. `rd_addr` equals the fetched address in that cycle and increments the next cycle.
- Reset asserted mid-transfer: `sda_t` = 1 asynchronously, all strobes 0, state IDLE.

## Structure
- Package `i2c_pkg`: the state enum (IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE) and the general-call address constant. `i2c` may later reuse the package.
- One sub-module, `i2c_in_filter`: synchronizer plus stability filter, instantiated twice (SCL, SDA).
- All FSM, shift register, bit counter and pointer logic is in `i2c_target`.

## Test plan
- Write of ptr 8'h10, then data 8'hA5, 8'h5A, then STOP → three ACKs. `wr_valid` pulses twice with (8'h10, 8'hA5) and (8'h11, 8'h5A); `busy` falls at STOP.
- Write ptr 8'h20, repeated START, read 3 bytes with ACK, ACK, NACK; `rd_data` = addr XOR 8'hFF → bytes 8'hDF, 8'hDE, 8'hDD on SDA. `rd_strobe` pulses 3 times; SDA is released after the NACK.
- Address 7'h57 write → no ACK (SDA stays high), no strobes, block stays in IGNORE until STOP.
- Write ptr 8'hFF, then data 8'h01, 8'h02 → writes at 8'hFF and 8'h00 (wrap).
- STOP injected after 4 data bits of a write → no `wr_valid`. The next transaction ACKs normally.
- Reset pulsed while the block drives a 0 data bit → `sda_t` = 1 within the reset cycle. After release, a clean read works.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding and reserved addresses.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic [6:0] GEN_CALL_ADDR = 7'h00;

endpackage

// File: rtl/i2c_in_filter.sv
// Pad input conditioning: 2-flop synchronizer followed by a glitch filter that
// only changes its output after FILTER_LEN consecutive differing samples.
module i2c_in_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int             CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(FILTER_LEN - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      cnt    <= CNT_LOAD;
      dout   <= 1'b1;
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
      // down-counter restarts whenever the synchronized input agrees with the output
      if (sync_2 == dout) begin
        cnt <= CNT_LOAD;
      end else if (cnt == '0) begin
        dout <= sync_2;
        cnt  <= CNT_LOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target.sv
// EEPROM-style I2C target: 8-bit auto-incrementing pointer into a fabric
// register space reached through a write-strobe / read-fetch port.
//
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting in address + R/W
// ADDR_ACK | driving ACK for our address
// WR_BYTE  | shifting in pointer or data byte
// WR_ACK   | driving ACK for a received byte
// RD_BYTE  | driving a read byte onto SDA
// RD_ACK   | sampling the controller's ACK/NACK
// IGNORE   | not addressed / read ended, wait for START or STOP
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h56,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_strobe,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  i2c_state_e state;
  logic       scl_f, sda_f, scl_d, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, tx_reg, ptr, rx_byte;
  logic       rw, ack_drv, first_byte;

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk  (clk),
    .rst  (rst),
    .din  (scl_i),
    .dout (scl_f)
  );

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk  (clk),
    .rst  (rst),
    .din  (sda_i),
    .dout (sda_f)
  );

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
  assign rx_byte   = {shreg[6:0], sda_f};
  assign sda_o     = 1'b0;
  assign rd_addr   = ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      scl_d      <= 1'b1;
      sda_d      <= 1'b1;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx_reg     <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      ack_drv    <= 1'b0;
      first_byte <= 1'b0;
      sda_t      <= 1'b1;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_strobe  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      scl_d     <= scl_f;
      sda_d     <= sda_f;
      wr_valid  <= 1'b0;
      rd_strobe <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= '0;
        ack_drv <= 1'b0;
        sda_t   <= 1'b1;
      end else if (stop_det) begin
        state   <= IDLE;
        ack_drv <= 1'b0;
        sda_t   <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (rx_byte[7:1] == DEV_ADDR && rx_byte[7:1] != GEN_CALL_ADDR) begin
                  state <= ADDR_ACK;
                  rw    <= rx_byte[0];
                  busy  <= 1'b1;
                end else begin
                  state <= IGNORE;
                  busy  <= 1'b0;
                end
              end
            end
          end
          ADDR_ACK, WR_ACK: begin
            // first fall starts the ACK bit, second fall ends it
            if (scl_fall) begin
              if (!ack_drv) begin
                sda_t   <= 1'b0;
                ack_drv <= 1'b1;
              end else begin
                sda_t   <= 1'b1;
                ack_drv <= 1'b0;
                bit_cnt <= '0;
                if (state == ADDR_ACK && rw) begin
                  state     <= RD_BYTE;
                  rd_strobe <= 1'b1;
                end else begin
                  state <= WR_BYTE;
                end
                if (state == ADDR_ACK) first_byte <= 1'b1;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= WR_ACK;
                if (first_byte) begin
                  ptr        <= rx_byte;
                  first_byte <= 1'b0;
                end else begin
                  wr_valid <= 1'b1;
                  wr_addr  <= ptr;
                  wr_data  <= rx_byte;
                  ptr      <= ptr + 8'd1;
                end
              end
            end
          end
          RD_BYTE: begin
            // fetch cycle: MSB goes out right away, the rest follow on SCL falls
            if (rd_strobe) begin
              sda_t  <= rd_data[7];
              tx_reg <= {rd_data[6:0], 1'b1};
              ptr    <= ptr + 8'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_t   <= 1'b1;
                bit_cnt <= '0;
                state   <= RD_ACK;
              end else begin
                sda_t   <= tx_reg[7];
                tx_reg  <= {tx_reg[6:0], 1'b1};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && sda_f) begin
              state <= IGNORE;
              busy  <= 1'b0;
            end else if (scl_fall) begin
              state     <= RD_BYTE;
              rd_strobe <= 1'b1;
              bit_cnt   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller plus a scoreboard that
// matches wr_valid / rd_strobe pulses against queued expectations.
module tb_i2c_target;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_i, sda_i, sda_o, sda_t, wr_valid, rd_strobe, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       sda_low_seen = 1'b0;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  always #5 clk = ~clk;

  assign scl_i   = scl_m;
  assign sda_i   = sda_m & sda_t;
  assign rd_data = rd_addr ^ 8'hFF;

  i2c_target #(.DEV_ADDR(7'h56), .FILTER_LEN(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_o     (sda_o),
    .sda_t     (sda_t),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_strobe (rd_strobe),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      if (!sda_t) sda_low_seen = 1'b1;
      if (wr_valid) begin
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected wr_valid: got addr %h data %h expected no write", wr_addr, wr_data);
        end else begin
          check("wr_valid addr/data", {wr_addr, wr_data}, exp_wr.pop_front());
        end
      end
      if (rd_strobe) begin
        if (exp_rd.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected rd_strobe: got addr %h expected no fetch", rd_addr);
        end else begin
          check("rd_strobe addr", 16'(rd_addr), 16'(exp_rd.pop_front()));
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic send_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q / 2);
    b = sda_i;    wait_clk(Q / 2);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) get_bit(d[i]);
    put_bit(nack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;

    wait_clk(3);
    check("reset sda_t", 16'(sda_t), 16'h1);
    check("reset busy", 16'(busy), 16'h0);
    check("reset wr_valid", 16'(wr_valid), 16'h0);
    check("reset rd_strobe", 16'(rd_strobe), 16'h0);
    check("reset wr_addr/data", {wr_addr, wr_data}, 16'h0000);
    check("reset rd_addr", 16'(rd_addr), 16'h0);
    check("sda_o", 16'(sda_o), 16'h0);
    rst = 1'b1;
    wait_clk(10);

    // write pointer 0x10 then two data bytes
    send_start();
    put_byte(8'hAC, ack); check("t1 addr ack", 16'(ack), 16'h0);
    check("t1 busy", 16'(busy), 16'h1);
    put_byte(8'h10, ack); check("t1 ptr ack", 16'(ack), 16'h0);
    exp_wr.push_back(16'h10A5);
    put_byte(8'hA5, ack); check("t1 data0 ack", 16'(ack), 16'h0);
    exp_wr.push_back(16'h115A);
    put_byte(8'h5A, ack); check("t1 data1 ack", 16'(ack), 16'h0);
    send_stop(); wait_clk(10);
    check("t1 busy after stop", 16'(busy), 16'h0);
    check("t1 writes seen", 16'(exp_wr.size()), 16'h0);

    // set pointer 0x20, repeated START, read three bytes
    send_start();
    put_byte(8'hAC, ack); check("t2 addr ack", 16'(ack), 16'h0);
    put_byte(8'h20, ack); check("t2 ptr ack", 16'(ack), 16'h0);
    send_start();
    exp_rd.push_back(8'h20);
    put_byte(8'hAD, ack); check("t2 raddr ack", 16'(ack), 16'h0);
    exp_rd.push_back(8'h21);
    get_byte(d, 1'b0); check("t2 byte0", 16'(d), 16'h00DF);
    exp_rd.push_back(8'h22);
    get_byte(d, 1'b0); check("t2 byte1", 16'(d), 16'h00DE);
    get_byte(d, 1'b1); check("t2 byte2", 16'(d), 16'h00DD);
    wait_clk(2);
    check("t2 sda released", 16'(sda_t), 16'h1);
    check("t2 busy after nack", 16'(busy), 16'h0);
    send_stop(); wait_clk(10);
    check("t2 fetches seen", 16'(exp_rd.size()), 16'h0);

    // foreign address and general call are ignored
    sda_low_seen = 1'b0;
    send_start();
    put_byte(8'hAE, ack); check("t3 addr 57 nack", 16'(ack), 16'h1);
    put_byte(8'h55, ack); check("t3 data nack", 16'(ack), 16'h1);
    check("t3 busy", 16'(busy), 16'h0);
    send_stop();
    send_start();
    put_byte(8'h00, ack); check("t3 general call nack", 16'(ack), 16'h1);
    send_stop(); wait_clk(10);
    check("t3 sda never low", 16'(sda_low_seen), 16'h0);

    // pointer wrap
    send_start();
    put_byte(8'hAC, ack); check("t4 addr ack", 16'(ack), 16'h0);
    put_byte(8'hFF, ack); check("t4 ptr ack", 16'(ack), 16'h0);
    exp_wr.push_back(16'hFF01);
    put_byte(8'h01, ack); check("t4 data0 ack", 16'(ack), 16'h0);
    exp_wr.push_back(16'h0002);
    put_byte(8'h02, ack); check("t4 data1 ack", 16'(ack), 16'h0);
    send_stop(); wait_clk(10);
    check("t4 writes seen", 16'(exp_wr.size()), 16'h0);

    // STOP after half a data byte, then a normal write
    send_start();
    put_byte(8'hAC, ack); check("t5 addr ack", 16'(ack), 16'h0);
    put_byte(8'h30, ack); check("t5 ptr ack", 16'(ack), 16'h0);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    send_stop(); wait_clk(10);
    check("t5 busy after partial", 16'(busy), 16'h0);
    send_start();
    put_byte(8'hAC, ack); check("t5 next addr ack", 16'(ack), 16'h0);
    put_byte(8'h40, ack); check("t5 next ptr ack", 16'(ack), 16'h0);
    exp_wr.push_back(16'h4077);
    put_byte(8'h77, ack); check("t5 next data ack", 16'(ack), 16'h0);
    send_stop(); wait_clk(10);
    check("t5 writes seen", 16'(exp_wr.size()), 16'h0);

    // reset while the target drives a 0 data bit (byte at 0x80 is 0x7F)
    send_start();
    put_byte(8'hAC, ack); check("t6 addr ack", 16'(ack), 16'h0);
    put_byte(8'h80, ack); check("t6 ptr ack", 16'(ack), 16'h0);
    send_start();
    exp_rd.push_back(8'h80);
    put_byte(8'hAD, ack); check("t6 raddr ack", 16'(ack), 16'h0);
    check("t6 driving 0", 16'(sda_t), 16'h0);
    #3 rst = 1'b0;
    #1;
    check("t6 sda_t in reset", 16'(sda_t), 16'h1);
    check("t6 rd_strobe in reset", 16'(rd_strobe), 16'h0);
    check("t6 busy in reset", 16'(busy), 16'h0);
    wait_clk(2);
    rst = 1'b1;
    check("t6 ptr after reset", 16'(rd_addr), 16'h0);
    send_stop(); wait_clk(10);
    send_start();
    put_byte(8'hAC, ack); check("t6 clean addr ack", 16'(ack), 16'h0);
    put_byte(8'h05, ack); check("t6 clean ptr ack", 16'(ack), 16'h0);
    send_start();
    exp_rd.push_back(8'h05);
    put_byte(8'hAD, ack); check("t6 clean raddr ack", 16'(ack), 16'h0);
    get_byte(d, 1'b1); check("t6 clean byte", 16'(d), 16'h00FA);
    send_stop(); wait_clk(10);
    check("t6 busy end", 16'(busy), 16'h0);
    check("t6 fetches seen", 16'(exp_rd.size()), 16'h0);
    check("end writes seen", 16'(exp_wr.size()), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
